// File: rtl/seq_det_pkg.sv
// Shared types and the "10011" detector step function for seq_det_scheduler.
// Contents:
//   det_state_t   - detector states S0..S4 (S4 = "1001" seen)
//   ctl_state_t   - controller states IDLE / SHIFT / RESP
//   seq_det_step  - one detector step; returns {next_state[2:0], hit}
package seq_det_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } ctl_state_t;

  // Overlapping Mealy detector. An illegal encoding steps back to S0.
  function automatic logic [3:0] seq_det_step(input logic [2:0] state, input logic x);
    logic [2:0] nxt;
    logic       hit;
    nxt = S0;
    hit = 1'b0;
    case (state)
      S0:      nxt = x ? S1 : S0;
      S1:      nxt = x ? S1 : S2;
      S2:      nxt = x ? S1 : S3;
      S3:      nxt = x ? S4 : S0;
      S4: begin
        nxt = x ? S1 : S2;
        hit = x;
      end
      default: nxt = S0;
    endcase
    return {nxt, hit};
  endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// Round-robin arbiter for seq_det_scheduler.
// Ports:
//   req   - request vector
//   ptr   - highest-priority index this round
//   grant - one-hot grant (all zero when no request)
//   idx   - index of the granted requester
module seq_det_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan from ptr upward with wrap; the first active request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one "10011" detector among NUM_REQ serial
// requesters. Each channel keeps its own detector context, so patterns that
// straddle consecutive words of one channel are still found.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (req_ready one-hot, IDLE only)
//   req_data              - word i at [i*DATA_W +: DATA_W], shifted MSB first
//   clr_ctx               - per-channel clear of saved detector state
//   rsp_valid/rsp_ready   - response handshake
//   rsp_id, rsp_count     - channel and number of detections in that word
import seq_det_pkg::*;

module seq_det_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           clr_ctx,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [CNT_W-1:0]             rsp_count
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(DATA_W + 1);

  ctl_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  cur;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        work;
  logic [CNT_W-1:0]  count;
  logic [BCNT_W-1:0] bit_cnt;
  logic [2:0]        ctx [NUM_REQ];

  logic [DATA_W-1:0]  words [NUM_REQ];
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               accept;
  logic [3:0]         step;
  logic [2:0]         nxt;
  logic               hit;
  logic               last_bit;
  logic               wb_en;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  seq_det_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Grant is only offered while idle; masked during reset so nothing is
  // advertised before the controller is running.
  assign req_ready = (state == IDLE && !reset) ? arb_grant : '0;
  assign accept    = |(req_valid & req_ready);

  assign step     = seq_det_step(work, shreg[DATA_W-1]);
  assign nxt      = step[3:1];
  assign hit      = step[0];
  assign last_bit = (bit_cnt == '0);
  assign wb_en    = (state == SHIFT) && last_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur       <= '0;
      shreg     <= '0;
      work      <= S0;
      count     <= '0;
      bit_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur     <= arb_idx;
            shreg   <= words[arb_idx];
            work    <= ctx[arb_idx];
            count   <= '0;
            bit_cnt <= BCNT_W'(DATA_W - 1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          work    <= nxt;
          count   <= count + CNT_W'(hit);
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt - BCNT_W'(1);
          if (last_bit) begin
            rr_ptr    <= (cur == IDX_W'(NUM_REQ - 1)) ? '0 : cur + IDX_W'(1);
            rsp_id    <= cur;
            rsp_count <= count + CNT_W'(hit);
            state     <= RESP;
          end
        end
        RESP: begin
          // rsp_valid rises one cycle after entry, then waits for the consumer.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          work      <= S0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Context store. A clear beats the writeback of the same channel; a clear
  // mid-word only touches the stored copy, never the working state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) ctx[i] <= S0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (clr_ctx[i]) begin
          ctx[i] <= S0;
        end else if (wb_en && cur == IDX_W'(i)) begin
          ctx[i] <= nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Self-checking bench for seq_det_scheduler: a reference detector model
// computes the expected count per word and pushes it to a scoreboard queue;
// responses pop and compare.
module tb_seq_det_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        clr_ctx;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDX_W-1:0]          rsp_id;
  logic [CNT_W-1:0]          rsp_count;

  int n_tests = 0;
  int n_fail  = 0;
  int mctx [NUM_REQ];

  typedef struct {
    int id;
    int cnt;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  seq_det_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clr_ctx   (clr_ctx),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference detector: transition table of the "10011" pattern.
  function automatic int m_next(input int s, input bit x);
    case (s)
      0: return x ? 1 : 0;
      1: return x ? 1 : 2;
      2: return x ? 1 : 3;
      3: return x ? 4 : 0;
      4: return x ? 1 : 2;
      default: return 0;
    endcase
  endfunction

  task automatic m_word(input int s0, input logic [7:0] d, output int cnt, output int s_end);
    int s;
    s   = s0;
    cnt = 0;
    for (int k = DATA_W - 1; k >= 0; k--) begin
      if (s == 4 && d[k]) cnt++;
      s = m_next(s, d[k]);
    end
    s_end = s;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    check_val({tag, "_rsp_count"}, 32'(rsp_count), 32'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    clr_ctx   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) mctx[i] = 0;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  // One word: waits for the grant (expected on channel ch), checks the
  // accept-to-rsp_valid latency, optional clr_ctx[ch] pulse at SHIFT cycle
  // clr_at (7 lands on the writeback edge), and hold cycles of backpressure.
  task automatic do_word(input int ch, input int clr_at, input int hold);
    logic [7:0] d;
    int n, cyc, cnt, s_end;
    bit busy_ready;
    exp_t e;
    #1;
    n = 0;
    while (req_ready == '0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) begin
      check_val("grant_timeout", 32'(req_ready), 32'(1 << ch));
      return;
    end
    check_val("grant", 32'(req_ready), 32'(1 << ch));
    d = req_data[ch*DATA_W +: DATA_W];
    m_word(mctx[ch], d, cnt, s_end);
    sb.push_back('{id: ch, cnt: cnt});
    @(posedge clk);
    #1;
    cyc = 0;
    busy_ready = 1'b0;
    while (!rsp_valid && cyc < 40) begin
      clr_ctx[ch] = (cyc == clr_at);
      if (req_ready != '0) busy_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    clr_ctx = '0;
    check_val("rsp_latency", 32'(cyc), 32'(DATA_W + 1));
    check_val("no_ready_busy", 32'(busy_ready), 32'd0);
    mctx[ch] = (clr_at == DATA_W - 1) ? 0 : s_end;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_val("rsp_id", 32'(rsp_id), 32'(e.id));
    check_val("rsp_count", 32'(rsp_count), 32'(e.cnt));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_id", 32'(rsp_id), 32'(e.id));
      check_val("hold_count", 32'(rsp_count), 32'(e.cnt));
      check_val("hold_no_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_val("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic send(input int ch, input logic [7:0] d, input int clr_at);
    req_data[ch*DATA_W +: DATA_W] = d;
    req_valid[ch] = 1'b1;
    do_word(ch, clr_at, 0);
    req_valid[ch] = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    clr_ctx   = '0;
    rsp_ready = 1'b0;
    do_reset();

    // Single word, one hit, ends in S0.
    send(0, 8'b10011000, -1);
    // Cross-word: second word completes a pattern started in the first.
    send(1, 8'b00000100, -1);
    send(1, 8'b11000000, -1);
    // Same with an idle clear in between: no detection.
    send(1, 8'b00000100, -1);
    clr_ctx[1] = 1'b1;
    @(posedge clk);
    #1;
    clr_ctx = '0;
    mctx[1] = 0;
    send(1, 8'b11000000, -1);
    // Channel 0 picks up from S0 after its first word.
    send(0, 8'b11000000, -1);

    // Round-robin with everyone requesting.
    do_reset();
    req_data  = {8'b10011001, 8'b00100110, 8'b01001100, 8'b10011100};
    req_valid = '1;
    do_word(0, -1, 0);
    do_word(1, -1, 0);
    do_word(2, -1, 0);
    do_word(3, -1, 0);
    do_word(0, -1, 0);
    req_valid = '0;

    // Backpressure: held response, then accept on the next cycle.
    req_data[2*DATA_W +: DATA_W] = 8'b11001110;
    req_data[3*DATA_W +: DATA_W] = 8'b01110011;
    req_valid = 4'b1100;
    do_word(2, -1, 3);
    check_val("accept_after_bp", 32'(req_ready), 32'(1 << 3));
    do_word(3, -1, 0);
    req_valid = '0;

    // Clear on the writeback edge wins; clear mid-word is overwritten.
    send(1, 8'b00000100, DATA_W - 1);
    send(1, 8'b11000000, -1);
    send(1, 8'b00000100, 3);
    send(1, 8'b11000000, -1);

    // Reset in the 4th SHIFT cycle of ch2.
    send(3, 8'b00000100, -1);
    req_data[2*DATA_W +: DATA_W] = 8'b10011011;
    req_valid[2] = 1'b1;
    #1;
    n = 0;
    while (req_ready == '0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("mid_grant", 32'(req_ready), 32'(1 << 2));
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check_zero_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) mctx[i] = 0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check_val("no_rsp_after_reset", 32'(seen), 32'd0);
    req_data[0 +: DATA_W] = 8'b10011000;
    req_valid = 4'b0101;
    do_word(0, -1, 0);
    do_word(2, -1, 0);
    req_valid = '0;
    send(3, 8'b11000000, -1);

    // Random single-channel traffic with occasional clears.
    for (int r = 0; r < 12; r++) begin
      int ch;
      int sel;
      ch  = int'($urandom_range(NUM_REQ - 1, 0));
      sel = int'($urandom_range(3, 0));
      if (sel == 0) begin
        clr_ctx[ch] = 1'b1;
        @(posedge clk);
        #1;
        clr_ctx = '0;
        mctx[ch] = 0;
      end
      send(ch, 8'($urandom), (sel == 1) ? 2 : (sel == 2) ? DATA_W - 1 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
